// File: rtl/branch_seq.sv
// Branch/jump sequencer: drives the shared ALU over several cycles to resolve BEQ..BGEU, JAL and JALR.
// Latency from accept: 3 cycles for BEQ/BNE/JAL/JALR, 4 for BLT/BGE/BLTU/BGEU, 1 for bad encodings.
// Backpressure: start is accepted only while busy is low; a start that arrives while busy is dropped.
module branch_seq #(
    parameter int          XLEN     = 32,
    parameter logic [3:0]  ALU_ADD  = 4'd0,
    parameter logic [3:0]  ALU_SUB  = 4'd1,
    parameter logic [3:0]  ALU_SLT  = 4'd2,
    parameter logic [3:0]  ALU_SLTU = 4'd3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_res,
    output logic            busy,
    output logic            done,
    output logic            taken,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_we,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_we,
    output logic            illegal
);

    localparam logic [6:0]      OP_BRANCH = 7'b1100011;
    localparam logic [6:0]      OP_JAL    = 7'b1101111;
    localparam logic [6:0]      OP_JALR   = 7'b1100111;
    localparam logic [XLEN-1:0] FOUR      = XLEN'(4);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SUB  = 3'd1,
        S_CMP  = 3'd2,
        S_LINK = 3'd3,
        S_TGT  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    state_t          w_dec_state;

    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc_next;
    logic [XLEN-1:0] r_rd_data;
    logic            r_is_link;
    logic            r_is_jalr;
    logic            r_eq;
    logic            r_lt;
    logic            r_taken;
    logic            w_cond;
    logic            w_accept;

    assign w_accept = (r_state == S_IDLE) && start;

    // First working state chosen straight from the raw encoding at accept time.
    always_comb begin
        w_dec_state = S_ERR;
        case (opcode)
            OP_BRANCH: if (funct3[2:1] != 2'b01) w_dec_state = S_SUB;
            OP_JAL:    w_dec_state = S_LINK;
            OP_JALR:   if (funct3 == 3'b000) w_dec_state = S_LINK;
            default:   w_dec_state = S_ERR;
        endcase
    end

    always_comb begin
        w_cond = 1'b0;
        if (r_is_link) begin
            w_cond = 1'b1;
        end else begin
            case (r_funct3)
                3'b000:         w_cond = r_eq;
                3'b001:         w_cond = !r_eq;
                3'b100, 3'b110: w_cond = r_lt;
                3'b101, 3'b111: w_cond = !r_lt;
                default:        w_cond = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = w_dec_state;
            S_SUB:   w_state_nxt = r_funct3[2] ? S_CMP : S_TGT;
            S_CMP:   w_state_nxt = S_TGT;
            S_LINK:  w_state_nxt = S_TGT;
            S_TGT:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_op  = ALU_ADD;
        done    = 1'b0;
        pc_we   = 1'b0;
        rd_we   = 1'b0;
        illegal = 1'b0;
        case (r_state)
            S_SUB: begin
                alu_a  = r_rs1;
                alu_b  = r_rs2;
                alu_op = ALU_SUB;
            end
            S_CMP: begin
                alu_a  = r_rs1;
                alu_b  = r_rs2;
                alu_op = r_funct3[1] ? ALU_SLTU : ALU_SLT;
            end
            S_LINK: begin
                alu_a = r_pc;
                alu_b = FOUR;
            end
            S_TGT: begin
                alu_a = r_is_jalr ? r_rs1 : r_pc;
                alu_b = w_cond ? r_imm : FOUR;
            end
            S_DONE: begin
                done = 1'b1;
                // A taken target that is not word aligned suppresses both writes.
                if (r_taken && r_pc_next[1]) begin
                    illegal = 1'b1;
                end else begin
                    pc_we = 1'b1;
                    rd_we = r_is_link;
                end
            end
            S_ERR: begin
                done    = 1'b1;
                illegal = 1'b1;
            end
            default: begin
                alu_a = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct3  <= '0;
            r_pc      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_imm     <= '0;
            r_pc_next <= '0;
            r_rd_data <= '0;
            r_is_link <= 1'b0;
            r_is_jalr <= 1'b0;
            r_eq      <= 1'b0;
            r_lt      <= 1'b0;
            r_taken   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_funct3  <= funct3;
                r_pc      <= pc;
                r_rs1     <= rs1_val;
                r_rs2     <= rs2_val;
                r_imm     <= imm;
                r_is_link <= (opcode == OP_JAL) || (opcode == OP_JALR);
                r_is_jalr <= (opcode == OP_JALR);
                r_eq      <= 1'b0;
                r_lt      <= 1'b0;
                r_taken   <= 1'b0;
            end
            case (r_state)
                S_SUB:  r_eq      <= (alu_res == '0);
                S_CMP:  r_lt      <= alu_res[0];
                S_LINK: r_rd_data <= alu_res;
                S_TGT: begin
                    r_taken   <= w_cond;
                    r_pc_next <= r_is_jalr ? {alu_res[XLEN-1:1], 1'b0} : alu_res;
                end
                default: r_eq <= r_eq;
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign taken   = r_taken;
    assign pc_next = r_pc_next;
    assign rd_data = r_rd_data;

endmodule

// File: tb/tb_branch_seq.sv
// Bench for branch_seq: directed plan cases, reset abort, then random instructions vs a reference model.
module tb_branch_seq;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [6:0]      opcode = '0;
    logic [2:0]      funct3 = '0;
    logic [XLEN-1:0] pc = '0;
    logic [XLEN-1:0] rs1_val = '0;
    logic [XLEN-1:0] rs2_val = '0;
    logic [XLEN-1:0] imm = '0;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_res;
    logic            busy;
    logic            done;
    logic            taken;
    logic [XLEN-1:0] pc_next;
    logic            pc_we;
    logic [XLEN-1:0] rd_data;
    logic            rd_we;
    logic            illegal;

    int total = 0;
    int bad   = 0;

    branch_seq #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .funct3(funct3),
        .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
        .busy(busy), .done(done), .taken(taken), .pc_next(pc_next), .pc_we(pc_we),
        .rd_data(rd_data), .rd_we(rd_we), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // The shared ALU the sequencer borrows.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'd0:    alu_res = alu_a + alu_b;
            4'd1:    alu_res = alu_a - alu_b;
            4'd2:    alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd3:    alu_res = {31'd0, alu_a < alu_b};
            default: alu_res = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural outcome of one control-transfer instruction.
    function automatic void model(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [31:0] p, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] im,
                                  output int lat, output logic tk, output logic [31:0] nxt,
                                  output logic [31:0] lnk, output logic ill, output logic pwe,
                                  output logic rwe, output logic is_err, output logic is_link);
        lat = 1; tk = 1'b0; nxt = '0; lnk = p + 32'd4; ill = 1'b0;
        pwe = 1'b0; rwe = 1'b0; is_err = 1'b0; is_link = 1'b0;
        if (op == 7'b1100011 && f3 != 3'd2 && f3 != 3'd3) begin
            case (f3)
                3'd0:    tk = (a == b);
                3'd1:    tk = (a != b);
                3'd4:    tk = ($signed(a) < $signed(b));
                3'd5:    tk = !($signed(a) < $signed(b));
                3'd6:    tk = (a < b);
                default: tk = !(a < b);
            endcase
            lat = (f3 >= 3'd4) ? 4 : 3;
            nxt = tk ? p + im : p + 32'd4;
        end else if (op == 7'b1101111) begin
            is_link = 1'b1; tk = 1'b1; lat = 3; nxt = p + im;
        end else if (op == 7'b1100111 && f3 == 3'd0) begin
            is_link = 1'b1; tk = 1'b1; lat = 3; nxt = (a + im) & ~32'h1;
        end else begin
            is_err = 1'b1; ill = 1'b1;
        end
        if (!is_err) begin
            ill = tk && nxt[1];
            pwe = !ill;
            rwe = is_link && !ill;
        end
    endfunction

    // Called and returns at a falling edge; start may be junked while busy to test dropping.
    task automatic run_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input bit hold);
        int          e_lat;
        logic        e_tk, e_ill, e_pwe, e_rwe, e_err, e_link;
        logic [31:0] e_nxt, e_lnk;
        int          cyc;
        bit          seen;
        logic        s_tk, s_ill, s_pwe, s_rwe;
        logic [31:0] s_nxt, s_lnk;
        model(op, f3, p, a, b, im, e_lat, e_tk, e_nxt, e_lnk, e_ill, e_pwe, e_rwe, e_err, e_link);
        cyc = 0; seen = 0;
        s_tk = 0; s_ill = 0; s_pwe = 0; s_rwe = 0; s_nxt = '0; s_lnk = '0;
        opcode = op; funct3 = f3; pc = p; rs1_val = a; rs2_val = b; imm = im; start = 1'b1;
        while (!seen && cyc < 12) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done) begin
                seen = 1;
                s_tk = taken; s_ill = illegal; s_pwe = pc_we; s_rwe = rd_we;
                s_nxt = pc_next; s_lnk = rd_data;
            end else begin
                chk({tag, "_midway"}, {28'd0, busy, pc_we, rd_we, illegal}, 32'h8);
            end
            start = hold;
            if (hold) begin
                opcode = 7'($urandom); funct3 = 3'($urandom);
                pc = $urandom; rs1_val = $urandom; rs2_val = $urandom; imm = $urandom;
            end
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_lat"}, 32'(cyc), 32'(e_lat));
            chk({tag, "_taken"}, {31'd0, s_tk}, {31'd0, e_tk});
            chk({tag, "_illegal"}, {31'd0, s_ill}, {31'd0, e_ill});
            chk({tag, "_pc_we"}, {31'd0, s_pwe}, {31'd0, e_pwe});
            chk({tag, "_rd_we"}, {31'd0, s_rwe}, {31'd0, e_rwe});
            if (!e_err) chk({tag, "_pc_next"}, s_nxt, e_nxt);
            if (e_link) chk({tag, "_rd_data"}, s_lnk, e_lnk);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin : stim
        logic [6:0]  r_op;
        logic [2:0]  r_f3;
        logic [31:0] r_a, r_b, r_pc, r_im;
        int          sel;

        #12;
        chk("reset_ctl", {27'd0, busy, done, taken, pc_we, rd_we}, 32'd0);
        chk("reset_ill", {31'd0, illegal}, 32'd0);
        chk("reset_alu", {28'd0, alu_op} | alu_a | alu_b, 32'd0);
        chk("reset_regs", pc_next | rd_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("beq",   7'b1100011, 3'd0, 32'h100, 32'h5, 32'h5, 32'h20, 0);
        run_op("blt",   7'b1100011, 3'd4, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF8, 1);
        run_op("bltu",  7'b1100011, 3'd6, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF8, 0);
        run_op("bge_eq", 7'b1100011, 3'd5, 32'h240, 32'h8000_0000, 32'h8000_0000, 32'h40, 0);
        run_op("bgeu",  7'b1100011, 3'd7, 32'h280, 32'h3, 32'h9, 32'h10, 0);
        run_op("jalr_mis", 7'b1100111, 3'd0, 32'h300, 32'h1001, 32'h0, 32'h2, 0);
        run_op("jalr_ok", 7'b1100111, 3'd0, 32'h300, 32'h1001, 32'h0, 32'h3, 1);
        run_op("jal",   7'b1101111, 3'd5, 32'h400, 32'h0, 32'h0, 32'hFFFF_FF00, 0);
        run_op("br_f3_2", 7'b1100011, 3'd2, 32'h500, 32'h1, 32'h1, 32'h8, 1);
        run_op("jalr_f3", 7'b1100111, 3'd1, 32'h500, 32'h1, 32'h1, 32'h8, 0);

        // Reset while the compare step is in flight.
        opcode = 7'b1100011; funct3 = 3'd4; pc = 32'h600;
        rs1_val = 32'h1; rs2_val = 32'h2; imm = 32'h10; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", {26'd0, busy, done, taken, pc_we, rd_we, illegal}, 32'd0);
        chk("rst_mid_alu", {28'd0, alu_op} | alu_a | alu_b, 32'd0);
        chk("rst_mid_regs", pc_next | rd_data, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_done", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_op("bne_post_rst", 7'b1100011, 3'd1, 32'h700, 32'h1, 32'h2, 32'h40, 0);

        for (int i = 0; i < 80; i++) begin
            sel  = $urandom_range(0, 9);
            r_f3 = 3'($urandom);
            if (sel < 6) begin
                r_op = 7'b1100011;
            end else if (sel == 6) begin
                r_op = 7'b1101111;
            end else if (sel == 7) begin
                r_op = 7'b1100111;
                r_f3 = 3'd0;
            end else if (sel == 8) begin
                r_op = 7'($urandom);
            end else begin
                r_op = 7'b1100111;
            end
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
            if ($urandom_range(0, 3) == 0) r_b = r_a ^ 32'h8000_0000;
            r_pc = $urandom & ~32'h3;
            r_im = $urandom_range(0, 1) ? $urandom : ($urandom & 32'h0000_0FFC) - 32'h800;
            run_op("rand", r_op, r_f3, r_pc, r_a, r_b, r_im, $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
